cdb_arbiter: RTL and testbench

Shares the common data bus between the execution-side result producers (four ALU reservation stations, branch station, LSQ) and broadcasts up to NUM_PORTS tagged results per cycle to the ROB, regfile and reservation stations. Each requester gets a one-entry holding register. Grants are round-robin with an age-based anti-starvation override. ROB flushes kill pending results by tag.

---
 rtl/cdb_arbiter_pkg.sv | 39 +++
 rtl/cdb_arbiter_rr_pick.sv | 39 +++
 rtl/cdb_arbiter.sv | 138 +++++++++++++
 tb/tb_cdb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: lane record, requester indices, sizing constants.
// No logic here beyond a one-hot to index helper.
// No flow control here; consumers apply their own.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ   = 6;
    localparam int CDB_NUM_PORTS = 2;
    localparam int CDB_TAG_W     = 3;
    localparam int CDB_DATA_W    = 32;
    localparam int CDB_SRC_W     = 3;

    // Fixed requester slots on the bus
    typedef enum logic [2:0] {
        REQ_RES1  = 3'd0,
        REQ_RES2  = 3'd1,
        REQ_RES3  = 3'd2,
        REQ_RES4  = 3'd3,
        REQ_RESBR = 3'd4,
        REQ_LSQ   = 3'd5
    } req_idx_e;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_lane_t;

    // Index of the set bit in a one-hot vector (0 when empty)
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// One-hot picker: lowest-index urgent request first, otherwise round-robin from start.
// Purely combinational, zero latency.
// No backpressure; the caller removes earlier picks from the mask.
module cdb_arbiter_rr_pick #(
    parameter int N = 6
) (
    input  logic [N-1:0] mask,
    input  logic [N-1:0] urgent,
    input  logic [2:0]   start,
    output logic [N-1:0] pick
);

    logic       found;
    logic [2:0] idx;

    // Urgent entries win in ascending order; else first request at or after start
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 3'd0;
        if (|(mask & urgent)) begin
            for (int i = 0; i < N; i++) begin
                if (mask[i] && urgent[i] && !found) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = 3'((int'(start) + k) % N);
                if (mask[idx] && !found) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold per producer, up to NUM_PORTS tagged results broadcast per cycle.
// One cycle from hold load to broadcast; each cdb_valid is a single-cycle pulse.
// req_ready drops while a requester's hold is full; flush-killed holds are dropped silently.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = CDB_NUM_REQ,
    parameter int NUM_PORTS    = CDB_NUM_PORTS,
    parameter int TAG_W        = CDB_TAG_W,
    parameter int DATA_W       = CDB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        flush,
    input  logic [(1<<TAG_W)-1:0]       kill_mask,
    output logic [NUM_PORTS-1:0]        cdb_valid,
    output logic [NUM_PORTS*TAG_W-1:0]  cdb_tag,
    output logic [NUM_PORTS*DATA_W-1:0] cdb_data,
    output logic [NUM_PORTS*3-1:0]      cdb_src,
    output logic [2:0]                  rr_ptr
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0]                hold_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]     hold_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]    hold_data;
    logic [NUM_REQ-1:0][AGE_W-1:0]     age;

    logic [NUM_REQ-1:0]                killed, eligible, starved, in_kill, grant;
    logic [NUM_PORTS:0][NUM_REQ-1:0]   avail;
    logic [NUM_PORTS-1:0][NUM_REQ-1:0] pick;
    logic [NUM_PORTS-1:0]              lane_hit;
    logic [NUM_PORTS-1:0][2:0]         lane_src;
    logic [NUM_PORTS-1:0][TAG_W-1:0]   lane_tag;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  lane_data;
    logic [2:0]                        rr_next;

    // Ready depends only on registered hold state, forced low during reset
    assign req_ready = ~hold_valid & {NUM_REQ{~rst}};

    // Per-requester eligibility, starvation and incoming-kill status
    always_comb begin
        killed   = '0;
        eligible = '0;
        starved  = '0;
        in_kill  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            killed[i]   = flush && kill_mask[hold_tag[i]];
            eligible[i] = hold_valid[i] && !killed[i];
            starved[i]  = (age[i] == AGE_W'(STARVE_LIMIT));
            in_kill[i]  = flush && kill_mask[req_tag[i*TAG_W +: TAG_W]];
        end
    end

    // Lane 0 picks first; each later lane sees the remaining requests only
    assign avail[0] = eligible;
    for (genvar l = 0; l < NUM_PORTS; l++) begin : g_lane
        cdb_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
            .mask   (avail[l]),
            .urgent (starved),
            .start  (rr_ptr),
            .pick   (pick[l])
        );
        assign avail[l+1]  = avail[l] & ~pick[l];
        assign lane_hit[l] = |pick[l];
        assign lane_src[l] = onehot_idx(8'(pick[l]));
    end
    assign grant = eligible & ~avail[NUM_PORTS];

    // Lane payload mux and next round-robin start after the last-filled lane
    always_comb begin
        lane_tag  = '0;
        lane_data = '0;
        rr_next   = rr_ptr;
        for (int l = 0; l < NUM_PORTS; l++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick[l][i]) begin
                    lane_tag[l]  = hold_tag[i];
                    lane_data[l] = hold_data[i];
                end
            end
            if (lane_hit[l]) begin
                rr_next = (lane_src[l] == 3'(NUM_REQ - 1)) ? 3'd0 : lane_src[l] + 3'd1;
            end
        end
    end

    // Hold registers: clear on grant or kill, load on accept, age while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= '0;
            hold_tag   <= '0;
            hold_data  <= '0;
            age        <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] || killed[i]) begin
                    hold_valid[i] <= 1'b0;
                end else if (req_valid[i] && !hold_valid[i]) begin
                    hold_valid[i] <= !in_kill[i];
                    hold_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                    hold_data[i]  <= req_data[i*DATA_W +: DATA_W];
                    age[i]        <= '0;
                end else if (eligible[i] && !starved[i]) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    // Broadcast lanes; empty lanes keep their last payload with valid low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int l = 0; l < NUM_PORTS; l++) begin
                cdb_valid[l] <= lane_hit[l];
                if (lane_hit[l]) begin
                    cdb_tag[l*TAG_W +: TAG_W]    <= lane_tag[l];
                    cdb_data[l*DATA_W +: DATA_W] <= lane_data[l];
                    cdb_src[l*3 +: 3]            <= lane_src[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a two-lane build and a one-lane build.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants in each step.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   req_valid = '0;
    logic [17:0]  req_tag   = '0;
    logic [191:0] req_data  = '0;
    logic [5:0]   req_ready;
    logic         flush = 1'b0;
    logic [7:0]   kill_mask = '0;
    logic [1:0]   cdb_valid;
    logic [5:0]   cdb_tag;
    logic [63:0]  cdb_data;
    logic [5:0]   cdb_src;
    logic [2:0]   rr_ptr;

    logic [5:0]   p1_req_valid = '0;
    logic [17:0]  p1_req_tag   = '0;
    logic [191:0] p1_req_data  = '0;
    logic [5:0]   p1_req_ready;
    logic [0:0]   p1_cdb_valid;
    logic [2:0]   p1_cdb_tag;
    logic [31:0]  p1_cdb_data;
    logic [2:0]   p1_cdb_src;
    logic [2:0]   p1_rr_ptr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(6), .NUM_PORTS(2), .TAG_W(3), .DATA_W(32), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .kill_mask(kill_mask), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src), .rr_ptr(rr_ptr)
    );

    cdb_arbiter #(.NUM_REQ(6), .NUM_PORTS(1), .TAG_W(3), .DATA_W(32), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(p1_req_valid), .req_tag(p1_req_tag), .req_data(p1_req_data),
        .req_ready(p1_req_ready), .flush(1'b0), .kill_mask(8'h00), .cdb_valid(p1_cdb_valid),
        .cdb_tag(p1_cdb_tag), .cdb_data(p1_cdb_data), .cdb_src(p1_cdb_src), .rr_ptr(p1_rr_ptr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] t, input logic [31:0] d);
        req_valid[i]         = 1'b1;
        req_tag[i*3 +: 3]    = t;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        req_valid = '0;
        p1_req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic found;

        // Reset state
        tick();
        tick();
        check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        check("rst_rr_ptr", 64'(rr_ptr), 64'h0);
        check("rst_ready_low", 64'(req_ready), 64'h0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'h0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(req_ready), 64'h3f);

        // Single request from res2
        set_req(int'(REQ_RES2), 3'd5, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        check("t1_ready_low", 64'(req_ready), 64'h3d);
        check("t1_no_early", 64'(cdb_valid), 64'h0);
        tick();
        check("t1_valid", 64'(cdb_valid), 64'h1);
        check("t1_tag", 64'(cdb_tag[2:0]), 64'h5);
        check("t1_data", 64'(cdb_data[31:0]), 64'hDEADBEEF);
        check("t1_src", 64'(cdb_src[2:0]), 64'h1);
        check("t1_ready_back", 64'(req_ready), 64'h3f);
        check("t1_rr_ptr", 64'(rr_ptr), 64'h2);
        tick();
        check("t1_pulse", 64'(cdb_valid), 64'h0);

        // All six at once, round-robin from 0
        do_reset();
        for (int i = 0; i < 6; i++) set_req(i, 3'(i), 32'(100 + i));
        tick();
        req_valid = '0;
        tick();
        check("t2_c1_valid", 64'(cdb_valid), 64'h3);
        check("t2_c1_src", 64'(cdb_src), 64'({3'd1, 3'd0}));
        check("t2_c1_tag", 64'(cdb_tag), 64'({3'd1, 3'd0}));
        tick();
        check("t2_c2_src", 64'(cdb_src), 64'({3'd3, 3'd2}));
        tick();
        check("t2_c3_src", 64'(cdb_src), 64'({3'd5, 3'd4}));
        check("t2_c3_data", cdb_data, {32'd105, 32'd104});
        check("t2_rr_ptr", 64'(rr_ptr), 64'h0);
        tick();
        check("t2_idle", 64'(cdb_valid), 64'h0);

        // res1-res4 keep re-requesting while the LSQ waits
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 32'(i));
        set_req(int'(REQ_LSQ), 3'd7, 32'h55);
        tick();
        req_valid[int'(REQ_LSQ)] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int l = 0; l < 2; l++) begin
                if (cdb_valid[l] && cdb_src[l*3 +: 3] == 3'd5) found = 1'b1;
            end
        end
        check("t3_lsq_granted", 64'(found), 64'h1);

        // Flush kills tags 3 and 6, including a request arriving during the flush
        do_reset();
        set_req(0, 3'd2, 32'h22);
        set_req(1, 3'd3, 32'h33);
        set_req(2, 3'd6, 32'h66);
        tick();
        req_valid = '0;
        set_req(3, 3'd6, 32'h77);
        flush = 1'b1;
        kill_mask = 8'b0100_1000;
        tick();
        req_valid = '0;
        flush = 1'b0;
        kill_mask = '0;
        check("t4_valid", 64'(cdb_valid), 64'h1);
        check("t4_tag", 64'(cdb_tag[2:0]), 64'h2);
        check("t4_src", 64'(cdb_src[2:0]), 64'h0);
        check("t4_holds_empty", 64'(req_ready), 64'h3f);
        tick();
        check("t4_no_killed", 64'(cdb_valid), 64'h0);

        // Reset asserted with lanes driven and holds full
        do_reset();
        for (int i = 0; i < 6; i++) set_req(i, 3'(i), 32'(i));
        tick();
        req_valid = '0;
        tick();
        check("t5_pre_valid", 64'(cdb_valid), 64'h3);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", 64'(cdb_valid), 64'h0);
        check("t5_ready_in_rst", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_no_stale", 64'(cdb_valid), 64'h0);
        check("t5_ready", 64'(req_ready), 64'h3f);
        tick();
        check("t5_no_stale2", 64'(cdb_valid), 64'h0);

        // Single-lane build, requesters 0 and 4 continuously
        do_reset();
        p1_req_valid = 6'b01_0001;
        p1_req_tag[2:0]   = 3'd1;
        p1_req_tag[14:12] = 3'd4;
        p1_req_data[31:0]    = 32'hA0;
        p1_req_data[159:128] = 32'hA4;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_valid", 64'(p1_cdb_valid), 64'h1);
            check("t6_src", 64'(p1_cdb_src), (k % 2 == 0) ? 64'h0 : 64'h4);
        end
        check("t6_tag", 64'(p1_cdb_tag), 64'h4);
        p1_req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
